// File: rtl/csr_regfile.sv
// rtl/csr_regfile.sv - machine-mode CSR file and trap/redirect controller
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   csr_ena/csr_wr_en/csr_rd_en     CSR access strobes from execute
//   csr_idx, wbck_csr_dat           CSR address and merged write data
//   read_csr_dat, csr_illegal       combinational read data / illegal access flag
//   exc_ecall/exc_ebreak/exc_mret   trap and return events, exc_pc their PC
//   instr_retire                    retirement strobe for minstret
//   flush_req, flush_pc             registered one-cycle redirect to fetch
//   mstatus_mie                     current global interrupt enable
`timescale 1ns/1ps

module csr_regfile #(
  parameter int          XLEN      = 64,
  parameter logic [63:0] MTVEC_RST = 64'h0000_0000_8000_0000,
  parameter int          HART_ID   = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            csr_ena,
  input  logic            csr_wr_en,
  input  logic            csr_rd_en,
  input  logic [11:0]     csr_idx,
  input  logic [XLEN-1:0] wbck_csr_dat,
  output logic [XLEN-1:0] read_csr_dat,
  output logic            csr_illegal,
  input  logic            exc_ecall,
  input  logic            exc_ebreak,
  input  logic            exc_mret,
  input  logic [XLEN-1:0] exc_pc,
  input  logic            instr_retire,
  output logic            flush_req,
  output logic [XLEN-1:0] flush_pc,
  output logic            mstatus_mie
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [1:0]      MXL        = (XLEN == 64) ? 2'd2 : 2'd1;
  localparam logic [XLEN-1:0] MISA_VAL   = {MXL, {(XLEN-2){1'b0}}} | XLEN'(32'h100);
  localparam logic [XLEN-1:0] MTVEC_INIT = MTVEC_RST[XLEN-1:0] & ALIGN_MASK;

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t          state, state_nxt;
  logic            mie, mpie;
  logic [XLEN-1:0] mtvec, mscratch, mepc, mcause, mcycle, minstret;

  logic            impl, read_only;
  logic [XLEN-1:0] sel_val;
  logic [XLEN-1:0] mstatus_val;
  logic            wr_fire;
  logic            trap, evt;

  // Only MIE/MPIE are stored; MPP is hardwired to machine mode.
  assign mstatus_val = XLEN'({2'b11, 3'b000, mpie, 3'b000, mie, 3'b000});

  always_comb begin
    impl      = 1'b1;
    read_only = 1'b0;
    sel_val   = '0;
    case (csr_idx)
      12'h300: sel_val = mstatus_val;
      12'h301: begin sel_val = MISA_VAL;       read_only = 1'b1; end
      12'h305: sel_val = mtvec;
      12'h340: sel_val = mscratch;
      12'h341: sel_val = mepc;
      12'h342: sel_val = mcause;
      12'hB00: sel_val = mcycle;
      12'hB02: sel_val = minstret;
      12'hF14: begin sel_val = XLEN'(HART_ID); read_only = 1'b1; end
      default: impl = 1'b0;
    endcase
  end

  assign read_csr_dat = (csr_ena && csr_rd_en && impl) ? sel_val : '0;
  assign csr_illegal  = csr_ena && (!impl || (csr_wr_en && read_only));
  assign wr_fire      = csr_ena && csr_wr_en && impl && !read_only;

  assign trap        = exc_ecall || exc_ebreak;
  assign evt         = trap || exc_mret;
  assign mstatus_mie = mie;

  always_comb begin
    state_nxt = state;
    flush_req = (state == S_FLUSH);
    case (state)
      S_IDLE:  if (evt) state_nxt = S_FLUSH;
      S_FLUSH: state_nxt = evt ? S_FLUSH : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      mie      <= 1'b0;
      mpie     <= 1'b0;
      mtvec    <= MTVEC_INIT;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mcycle   <= '0;
      minstret <= '0;
      flush_pc <= '0;
    end else begin
      state <= state_nxt;

      // mstatus: trap entry and mret both own MIE/MPIE over a software write.
      if (trap) begin
        mpie <= mie;
        mie  <= 1'b0;
      end else if (exc_mret) begin
        mie  <= mpie;
        mpie <= 1'b1;
      end else if (wr_fire && csr_idx == 12'h300) begin
        mie  <= wbck_csr_dat[3];
        mpie <= wbck_csr_dat[7];
      end

      if (wr_fire && csr_idx == 12'h305) mtvec    <= wbck_csr_dat & ALIGN_MASK;
      if (wr_fire && csr_idx == 12'h340) mscratch <= wbck_csr_dat;

      if (trap)                               mepc <= exc_pc & ALIGN_MASK;
      else if (wr_fire && csr_idx == 12'h341) mepc <= wbck_csr_dat & ALIGN_MASK;

      if (exc_ecall)                          mcause <= XLEN'(11);
      else if (exc_ebreak)                    mcause <= XLEN'(3);
      else if (wr_fire && csr_idx == 12'h342) mcause <= wbck_csr_dat;

      if (wr_fire && csr_idx == 12'hB00) mcycle <= wbck_csr_dat;
      else                               mcycle <= mcycle + 1'b1;

      if (wr_fire && csr_idx == 12'hB02) minstret <= wbck_csr_dat;
      else if (instr_retire)             minstret <= minstret + 1'b1;

      // Targets use pre-edge mtvec/mepc so a same-cycle write does not leak in.
      if (trap)          flush_pc <= mtvec & ALIGN_MASK;
      else if (exc_mret) flush_pc <= mepc;
    end
  end

endmodule

// File: tb/tb_csr_regfile.sv
// tb/tb_csr_regfile.sv - scoreboard testbench for csr_regfile
`timescale 1ns/1ps

module tb_csr_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csr_ena, csr_wr_en, csr_rd_en;
  logic [11:0] csr_idx;
  logic [63:0] wbck_csr_dat;
  logic [63:0] read_csr_dat;
  logic        csr_illegal;
  logic        exc_ecall, exc_ebreak, exc_mret;
  logic [63:0] exc_pc;
  logic        instr_retire;
  logic        flush_req;
  logic [63:0] flush_pc;
  logic        mstatus_mie;

  always #5 clk = ~clk;

  csr_regfile #(.XLEN(64), .MTVEC_RST(64'h0000_0000_8000_0000), .HART_ID(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .csr_ena(csr_ena), .csr_wr_en(csr_wr_en), .csr_rd_en(csr_rd_en),
    .csr_idx(csr_idx), .wbck_csr_dat(wbck_csr_dat),
    .read_csr_dat(read_csr_dat), .csr_illegal(csr_illegal),
    .exc_ecall(exc_ecall), .exc_ebreak(exc_ebreak), .exc_mret(exc_mret),
    .exc_pc(exc_pc), .instr_retire(instr_retire),
    .flush_req(flush_req), .flush_pc(flush_pc), .mstatus_mie(mstatus_mie)
  );

  typedef struct {
    logic [63:0] rdat;
    logic        ill;
    logic        fr;
    logic [63:0] fpc;
    logic        mie;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state
  bit          m_mie, m_mpie, m_flush;
  logic [63:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mcycle, m_minstret, m_fpc;

  function automatic bit is_impl(logic [11:0] a);
    return a inside {12'h300, 12'h301, 12'h305, 12'h340, 12'h341,
                     12'h342, 12'hB00, 12'hB02, 12'hF14};
  endfunction

  function automatic bit is_ro(logic [11:0] a);
    return (a == 12'h301) || (a == 12'hF14);
  endfunction

  function automatic logic [63:0] m_read(logic [11:0] a);
    case (a)
      12'h300: return 64'h1800 + (m_mpie ? 64'h80 : 64'h0) + (m_mie ? 64'h8 : 64'h0);
      12'h301: return 64'h8000_0000_0000_0100;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'hB00: return m_mcycle;
      12'hB02: return m_minstret;
      12'hF14: return 64'd3;
      default: return 64'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_mie = 0; m_mpie = 0; m_flush = 0;
    m_mtvec = 64'h8000_0000; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
    m_mcycle = 0; m_minstret = 0; m_fpc = 0;
  endtask

  task automatic model_edge(input bit ena, wr, input logic [11:0] idx, input logic [63:0] wd,
                            input bit ec, eb, mr, input logic [63:0] pc, input bit ret);
    bit          trap, evt, wok;
    bit          o_mie, o_mpie;
    logic [63:0] o_mtvec, o_mepc, n_cyc, n_ret;
    trap = ec || eb;
    evt  = trap || mr;
    wok  = ena && wr && is_impl(idx) && !is_ro(idx);
    o_mie = m_mie; o_mpie = m_mpie; o_mtvec = m_mtvec; o_mepc = m_mepc;
    n_cyc = m_mcycle + 64'd1;
    n_ret = m_minstret + (ret ? 64'd1 : 64'd0);
    if (wok) begin
      case (idx)
        12'h300: if (!evt) begin m_mie = wd[3]; m_mpie = wd[7]; end
        12'h305: m_mtvec = {wd[63:2], 2'b00};
        12'h340: m_mscratch = wd;
        12'h341: if (!trap) m_mepc = {wd[63:2], 2'b00};
        12'h342: if (!trap) m_mcause = wd;
        12'hB00: n_cyc = wd;
        12'hB02: n_ret = wd;
        default: ;
      endcase
    end
    if (ec)      begin m_mepc = {pc[63:2], 2'b00}; m_mcause = 64'd11; end
    else if (eb) begin m_mepc = {pc[63:2], 2'b00}; m_mcause = 64'd3;  end
    if (trap)    begin m_mpie = o_mie; m_mie = 0; m_fpc = o_mtvec; end
    else if (mr) begin m_mie = o_mpie; m_mpie = 1; m_fpc = o_mepc; end
    m_mcycle   = n_cyc;
    m_minstret = n_ret;
    m_flush    = evt;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drives one cycle of stimulus, queues what the DUT must show during it,
  // then advances the model across the clock edge.
  task automatic step(input bit ena, wr, rd, input logic [11:0] idx, input logic [63:0] wd,
                      input bit ec, eb, mr, input logic [63:0] pc, input bit ret,
                      input string nm);
    exp_t e;
    csr_ena = ena; csr_wr_en = wr; csr_rd_en = rd; csr_idx = idx; wbck_csr_dat = wd;
    exc_ecall = ec; exc_ebreak = eb; exc_mret = mr; exc_pc = pc; instr_retire = ret;
    e.rdat = (ena && rd && is_impl(idx)) ? m_read(idx) : 64'd0;
    e.ill  = ena && (!is_impl(idx) || (wr && is_ro(idx)));
    e.fr   = m_flush;
    e.fpc  = m_fpc;
    e.mie  = m_mie;
    e.name = nm;
    sb.push_back(e);
    @(posedge clk);
    model_edge(ena, wr, idx, wd, ec, eb, mr, pc, ret);
    #1;
  endtask

  task automatic rd_csr(input logic [11:0] a, input string nm);
    step(1, 0, 1, a, 64'd0, 0, 0, 0, 64'd0, 0, nm);
  endtask

  task automatic wr_csr(input logic [11:0] a, input logic [63:0] d, input string nm);
    step(1, 1, 0, a, d, 0, 0, 0, 64'd0, 0, nm);
  endtask

  // Monitor: every cycle the DUT presents outputs, compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, ".rdat"}, read_csr_dat, e.rdat);
        check({e.name, ".illegal"}, {63'd0, csr_illegal}, {63'd0, e.ill});
        check({e.name, ".flush_req"}, {63'd0, flush_req}, {63'd0, e.fr});
        check({e.name, ".mie"}, {63'd0, mstatus_mie}, {63'd0, e.mie});
        if (e.fr) check({e.name, ".flush_pc"}, flush_pc, e.fpc);
      end else if (flush_req) begin
        checks++;
        failures++;
        $display("FAIL unexpected_flush: got flush_req=1 expected 0");
      end
    end
  end

  initial begin
    logic [11:0] addrs [9];
    logic [11:0] a;
    int          wait_cnt;
    addrs = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB02, 12'hF14};

    rst_n = 0;
    csr_ena = 0; csr_wr_en = 0; csr_rd_en = 0; csr_idx = 0; wbck_csr_dat = 0;
    exc_ecall = 0; exc_ebreak = 0; exc_mret = 0; exc_pc = 0; instr_retire = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_flush_pc", flush_pc, 64'd0);
    rst_n = 1;

    rd_csr(12'h305, "rst_mtvec");
    rd_csr(12'h301, "rst_misa");
    rd_csr(12'hF14, "rst_mhartid");
    rd_csr(12'h300, "rst_mstatus");
    rd_csr(12'h7C0, "unimpl_read");

    wr_csr(12'h340, 64'hDEAD_BEEF_0123_4567, "wr_mscratch");
    rd_csr(12'h340, "rd_mscratch");
    step(1, 1, 1, 12'hF14, 64'd99, 0, 0, 0, 64'd0, 0, "wr_mhartid");
    rd_csr(12'hF14, "rd_mhartid");

    wr_csr(12'h305, 64'h8000_0103, "wr_mtvec");
    wr_csr(12'h300, 64'h8, "wr_mie");
    step(0, 0, 0, 12'h0, 64'd0, 1, 0, 0, 64'h8000_0042, 0, "ecall");
    rd_csr(12'h341, "trap_mepc");
    rd_csr(12'h342, "trap_mcause");
    rd_csr(12'h300, "trap_mstatus");
    step(0, 0, 0, 12'h0, 64'd0, 0, 0, 1, 64'd0, 0, "mret");
    rd_csr(12'h300, "mret_mstatus");

    step(1, 1, 0, 12'h342, 64'd5, 0, 1, 0, 64'h8000_0200, 0, "ebreak_vs_wr");
    rd_csr(12'h342, "ebreak_mcause");
    step(0, 0, 0, 12'h0, 64'd0, 1, 0, 1, 64'h8000_0300, 0, "ecall_vs_mret");
    rd_csr(12'h341, "ecall_mret_mepc");
    step(0, 0, 0, 12'h0, 64'd0, 1, 0, 0, 64'h8000_0404, 0, "b2b_ecall");
    step(0, 0, 0, 12'h0, 64'd0, 0, 1, 0, 64'h8000_0508, 0, "b2b_ebreak");
    step(0, 0, 0, 12'h0, 64'd0, 0, 0, 1, 64'd0, 0, "b2b_mret");
    rd_csr(12'h300, "b2b_mstatus");

    wr_csr(12'hB00, 64'hFFFF_FFFF_FFFF_FFFE, "wr_mcycle");
    rd_csr(12'hB00, "mcycle_a");
    rd_csr(12'hB00, "mcycle_b");
    rd_csr(12'hB00, "mcycle_wrap");
    rd_csr(12'hB02, "minstret_pre");
    for (int i = 0; i < 5; i++) step(0, 0, 0, 12'h0, 64'd0, 0, 0, 0, 64'd0, 1, "retire");
    rd_csr(12'hB02, "minstret_post");
    step(1, 1, 0, 12'hB02, 64'd100, 0, 0, 0, 64'd0, 1, "wr_minstret_vs_ret");
    rd_csr(12'hB02, "minstret_wr");

    step(0, 0, 0, 12'h0, 64'd0, 1, 0, 0, 64'h8000_0600, 0, "pre_reset_ecall");
    rst_n = 0;
    csr_ena = 0; csr_wr_en = 0; csr_rd_en = 0;
    exc_ecall = 0; exc_ebreak = 0; exc_mret = 0; instr_retire = 0;
    #1;
    check("async_rst_flush", {63'd0, flush_req}, 64'd0);
    model_reset();
    begin
      exp_t e;
      e.rdat = 0; e.ill = 0; e.fr = 0; e.fpc = 0; e.mie = 0; e.name = "in_reset";
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    rst_n = 1;
    rd_csr(12'h340, "post_rst_mscratch");
    rd_csr(12'h305, "post_rst_mtvec");

    for (int i = 0; i < 300; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 12'($urandom) : addrs[$urandom_range(0, 8)];
      step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           a, {$urandom, $urandom},
           $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0,
           {$urandom, $urandom}, $urandom_range(0, 1) == 1, "rand");
    end
    step(0, 0, 0, 12'h0, 64'd0, 0, 0, 0, 64'd0, 0, "tail");

    wait_cnt = 0;
    while (sb.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
